// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding.
package uart_pkg;

  localparam int unsigned DefaultDataWidth  = 8;
  localparam int unsigned DefaultOversample = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; reset value is selectable.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: mid-bit oversampled frame recovery into a valid/ack holding
// register, with one-clock framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned OVERSAMPLE = DefaultOversample
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baudTick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  frameErr,
  output logic                  overrun
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

  logic rx_s;

  uart_rx_state_e state_q, state_d;

  logic [TickW-1:0]      tick_cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  logic cnt_clr, cnt_inc, bit_clr, shift_en, load, stop_bad;
  logic at_mid, at_last;

  uart_sync2 #(
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign at_mid  = baudTick && (tick_cnt_q == TickMid);
  assign at_last = baudTick && (tick_cnt_q == TickLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: if (at_mid) state_d = rx_s ? StIdle : StData;
      StData:  if (at_last && (bit_cnt_q == BitLast)) state_d = StStop;
      StStop:  if (at_last) state_d = rx_s ? StIdle : StBreak;
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ticks are only counted while a frame is in flight; idle and break hold the count at zero.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      StStart: begin
        if (at_mid) begin
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
        end else if (baudTick) begin
          cnt_inc = 1'b1;
        end
      end
      StData: begin
        if (at_last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else if (baudTick) begin
          cnt_inc = 1'b1;
        end
      end
      StStop: begin
        if (at_last) begin
          cnt_clr  = 1'b1;
          load     = rx_s;
          stop_bad = !rx_s;
        end else if (baudTick) begin
          cnt_inc = 1'b1;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      if (cnt_clr) begin
        tick_cnt_q <= '0;
      end else if (cnt_inc) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (bit_clr) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
      end
    end
  end

  // A load always wins over a same-cycle ack, so the fresh byte is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        data_q <= shift_q;
      end
      valid_q     <= load | (valid_q & ~rx_ack);
      frame_err_q <= stop_bad;
      overrun_q   <= load & valid_q & ~rx_ack;
    end
  end

  assign dataOut  = data_q;
  assign rx_valid = valid_q;
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;

endmodule
